// File: rtl/game_pkg.sv
// Shared 2048 game definitions: direction codes, scheduler states and direction decode helpers.
// Used by the button front-end, the grid datapath and the move scheduler.
package game_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [15:0] MOVE_COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_WAIT_START = 3'd0,
        ST_IDLE       = 3'd1,
        ST_MOVE       = 3'd2,
        ST_SPAWN      = 3'd3,
        ST_PROBE      = 3'd4,
        ST_OVER       = 3'd5
    } state_t;

    // Right and down both push tiles toward the high row index.
    function automatic logic dir_push_right(input logic [1:0] dir);
        return (dir == DIR_RIGHT) || (dir == DIR_DOWN);
    endfunction

    function automatic logic dir_transposed(input logic [1:0] dir);
        return (dir == DIR_UP) || (dir == DIR_DOWN);
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Bundle between the move scheduler and its neighbours (button front-end, grid datapath, spawner).
// master = scheduler side, slave = front-end/datapath side.
interface move_scheduler_if;

    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        restart;
    logic        no_spawn;
    logic [1:0]  row_idx;
    logic        push_right;
    logic        use_transposed;
    logic        row_write_en;
    logic        row_changed;
    logic        grid_clear;
    logic        spawn_valid;
    logic        spawn_ready;
    logic        busy;
    logic        game_over;
    logic [15:0] move_count;

    modport master (
        input  move_valid, move_dir, restart, no_spawn, row_changed, spawn_ready,
        output move_ready, row_idx, push_right, use_transposed, row_write_en,
               grid_clear, spawn_valid, busy, game_over, move_count
    );

    modport slave (
        output move_valid, move_dir, restart, no_spawn, row_changed, spawn_ready,
        input  move_ready, row_idx, push_right, use_transposed, row_write_en,
               grid_clear, spawn_valid, busy, game_over, move_count
    );

endinterface

// File: rtl/game_over_prober.sv
// Walks direction 0..3 x row 0..3 through the push/merge unit while active and flags the first change.
// One step per cycle; counters return to zero whenever inactive or on a hit.
module game_over_prober (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       row_changed,
    output logic [1:0] probe_dir,
    output logic [1:0] probe_row,
    output logic       hit,
    output logic       exhausted
);

    logic [3:0] step_q;

    assign probe_dir = step_q[3:2];
    assign probe_row = step_q[1:0];
    assign hit       = active && row_changed;
    assign exhausted = active && !row_changed && (step_q == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 4'd0;
        end else if (!active || hit) begin
            step_q <= 4'd0;
        end else begin
            step_q <= step_q + 4'd1;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Sequences a 2048 move: four row passes, tile spawns, then a read-only game-over probe.
// move_ready is a pure state decode; requests arriving while busy are dropped, not queued.
module move_scheduler
    import game_pkg::*;
#(
    parameter int START_TILES = 2,
    parameter int MOVE_TILES  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    move_scheduler_if.master   bus
);

    localparam logic [1:0] START_CNT = 2'(START_TILES);
    localparam logic [1:0] MOVE_CNT  = 2'(MOVE_TILES);

    state_t      state_q, state_d;
    logic [1:0]  dir_q;
    logic        no_spawn_q;
    logic        changed_q;
    logic [1:0]  row_q;
    logic [1:0]  spawn_cnt_q;
    logic [15:0] move_count_q;
    logic        game_over_q;
    logic        grid_clear_q;

    logic [1:0]  probe_dir;
    logic [1:0]  probe_row;
    logic        probe_hit;
    logic        probe_exhausted;

    logic start_req;
    logic move_req;
    logic last_row;
    logic changed_final;
    logic move_done_changed;
    logic spawn_done;

    // A restart is only honoured together with move_valid; in WAIT_START any request starts the game.
    assign start_req = bus.move_valid &&
                       ((state_q == ST_WAIT_START) ||
                        (bus.restart && ((state_q == ST_IDLE) || (state_q == ST_OVER))));
    assign move_req          = bus.move_valid && !bus.restart && (state_q == ST_IDLE);
    assign last_row          = (row_q == 2'd3);
    assign changed_final     = changed_q || bus.row_changed;
    assign move_done_changed = (state_q == ST_MOVE) && last_row && changed_final;
    assign spawn_done        = bus.spawn_ready && (spawn_cnt_q == 2'd1);

    game_over_prober u_prober (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (state_q == ST_PROBE),
        .row_changed (bus.row_changed),
        .probe_dir   (probe_dir),
        .probe_row   (probe_row),
        .hit         (probe_hit),
        .exhausted   (probe_exhausted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_START: if (start_req) state_d = ST_SPAWN;
            ST_IDLE: begin
                if (start_req)     state_d = ST_SPAWN;
                else if (move_req) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (last_row) begin
                    if (!changed_final)  state_d = ST_IDLE;
                    else if (no_spawn_q) state_d = ST_PROBE;
                    else                 state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: if (spawn_done) state_d = ST_PROBE;
            ST_PROBE: begin
                if (probe_hit)            state_d = ST_IDLE;
                else if (probe_exhausted) state_d = ST_OVER;
            end
            ST_OVER: if (start_req) state_d = ST_SPAWN;
            default: state_d = ST_WAIT_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_LEFT;
            no_spawn_q   <= 1'b0;
            changed_q    <= 1'b0;
            row_q        <= 2'd0;
            spawn_cnt_q  <= 2'd0;
            move_count_q <= 16'd0;
            game_over_q  <= 1'b0;
            grid_clear_q <= 1'b0;
        end else begin
            grid_clear_q <= start_req;

            if (move_req) begin
                dir_q      <= bus.move_dir;
                no_spawn_q <= bus.no_spawn;
                changed_q  <= 1'b0;
                row_q      <= 2'd0;
            end else if (state_q == ST_MOVE) begin
                changed_q <= changed_final;
                row_q     <= row_q + 2'd1;
            end

            if (start_req) begin
                spawn_cnt_q <= START_CNT;
            end else if (move_done_changed && !no_spawn_q) begin
                spawn_cnt_q <= MOVE_CNT;
            end else if ((state_q == ST_SPAWN) && bus.spawn_ready) begin
                spawn_cnt_q <= spawn_cnt_q - 2'd1;
            end

            if (start_req) begin
                move_count_q <= 16'd0;
            end else if (move_done_changed && (move_count_q != MOVE_COUNT_MAX)) begin
                move_count_q <= move_count_q + 16'd1;
            end

            if (start_req) begin
                game_over_q <= 1'b0;
            end else if (probe_exhausted) begin
                game_over_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.move_ready     = (state_q == ST_WAIT_START) || (state_q == ST_IDLE) || (state_q == ST_OVER);
        bus.busy           = !bus.move_ready;
        bus.row_idx        = 2'd0;
        bus.push_right     = 1'b0;
        bus.use_transposed = 1'b0;
        bus.row_write_en   = 1'b0;
        bus.spawn_valid    = (state_q == ST_SPAWN);
        bus.grid_clear     = grid_clear_q;
        bus.game_over      = game_over_q;
        bus.move_count     = move_count_q;
        case (state_q)
            ST_MOVE: begin
                bus.row_idx        = row_q;
                bus.push_right     = dir_push_right(dir_q);
                bus.use_transposed = dir_transposed(dir_q);
                bus.row_write_en   = 1'b1;
            end
            ST_PROBE: begin
                bus.row_idx        = probe_row;
                bus.push_right     = dir_push_right(probe_dir);
                bus.use_transposed = dir_transposed(probe_dir);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Randomized bench for move_scheduler: a transaction-level game model predicts row walks, spawns,
// probe length, game_over and move_count for each request.
module tb_move_scheduler;
    import game_pkg::*;

    localparam int START_T = 2;
    localparam int MOVE_T  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] model_count = 16'd0;
    logic        model_over  = 1'b0;

    move_scheduler_if bus ();

    move_scheduler #(.START_TILES(START_T), .MOVE_TILES(MOVE_T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spawn_phase(input int n, input bit first_clear);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 100) begin
            check("spawn_valid", 32'(bus.spawn_valid), 32'(1));
            check("spawn_wr", 32'(bus.row_write_en), 32'(0));
            check("spawn_clear", 32'(bus.grid_clear), 32'(first_clear && cyc == 0));
            bus.spawn_ready = 1'($urandom % 2);
            bus.move_valid  = 1'($urandom % 2);
            if (bus.spawn_ready) got++;
            @(negedge clk);
            cyc++;
        end
        bus.spawn_ready = 1'b0;
        bus.move_valid  = 1'b0;
        check("spawn_count", 32'(got), 32'(n));
    endtask

    task automatic probe_phase(input int hit);
        for (int j = 0; j < 16; j++) begin
            int d = j / 4;
            check("probe_row", 32'(bus.row_idx), 32'(j % 4));
            check("probe_pr", 32'(bus.push_right), 32'(d == 1 || d == 3));
            check("probe_tr", 32'(bus.use_transposed), 32'(d >= 2));
            check("probe_wr", 32'(bus.row_write_en), 32'(0));
            check("probe_busy", 32'(bus.busy), 32'(1));
            check("probe_spawn", 32'(bus.spawn_valid), 32'(0));
            bus.row_changed = (j == hit);
            bus.move_valid  = 1'($urandom % 2);
            @(negedge clk);
            if (j == hit) break;
        end
        bus.row_changed = 1'b0;
        bus.move_valid  = 1'b0;
        model_over = (hit >= 16);
        check("post_probe_ready", 32'(bus.move_ready), 32'(1));
        check("post_probe_over", 32'(bus.game_over), 32'(model_over));
    endtask

    task automatic do_start(input bit rs, input int hit);
        check("start_ready", 32'(bus.move_ready), 32'(1));
        bus.move_valid = 1'b1;
        bus.restart    = rs;
        bus.move_dir   = 2'($urandom);
        @(negedge clk);
        bus.move_valid = 1'b0;
        bus.restart    = 1'b0;
        model_count = 16'd0;
        check("start_count", 32'(bus.move_count), 32'(model_count));
        check("start_over", 32'(bus.game_over), 32'(0));
        spawn_phase(START_T, 1'b1);
        probe_phase(hit);
    endtask

    task automatic do_move(input logic [1:0] d, input logic [3:0] mask, input bit ns, input int hit);
        check("move_ready", 32'(bus.move_ready), 32'(1));
        bus.move_valid = 1'b1;
        bus.restart    = 1'b0;
        bus.move_dir   = d;
        bus.no_spawn   = ns;
        @(negedge clk);
        bus.no_spawn = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            check("move_row", 32'(bus.row_idx), 32'(k));
            check("move_wr", 32'(bus.row_write_en), 32'(1));
            check("move_pr", 32'(bus.push_right), 32'(d == DIR_RIGHT || d == DIR_DOWN));
            check("move_tr", 32'(bus.use_transposed), 32'(d == DIR_UP || d == DIR_DOWN));
            check("move_busy", 32'(bus.move_ready), 32'(0));
            check("move_spawn", 32'(bus.spawn_valid), 32'(0));
            bus.row_changed = mask[k];
            bus.move_valid  = 1'($urandom % 2);
            bus.move_dir    = 2'($urandom);
            @(negedge clk);
        end
        bus.row_changed = 1'b0;
        bus.move_valid  = 1'b0;
        if (mask == 4'd0) begin
            check("nochg_ready", 32'(bus.move_ready), 32'(1));
            check("nochg_spawn", 32'(bus.spawn_valid), 32'(0));
        end else begin
            if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
            if (!ns) spawn_phase(MOVE_T, 1'b0);
            else check("nospawn_probe", 32'(bus.spawn_valid), 32'(0));
            probe_phase(hit);
        end
        check("move_count", 32'(bus.move_count), 32'(model_count));
    endtask

    initial begin
        bus.move_valid  = 1'b0;
        bus.move_dir    = 2'd0;
        bus.restart     = 1'b0;
        bus.no_spawn    = 1'b0;
        bus.row_changed = 1'b0;
        bus.spawn_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.move_ready), 32'(1));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_outs", 32'({bus.spawn_valid, bus.row_write_en, bus.grid_clear, bus.game_over,
                               bus.use_transposed, bus.push_right, bus.row_idx}), 32'(0));
        check("rst_count", 32'(bus.move_count), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_start(1'b0, 2);
        do_move(DIR_DOWN, 4'b0100, 1'b0, 0);
        do_move(DIR_LEFT, 4'b0000, 1'b0, 0);
        do_move(DIR_UP, 4'b1001, 1'b1, 5);
        do_move(DIR_RIGHT, 4'b0010, 1'b0, 16);

        // Game over: plain moves are ignored, only restart gets through.
        for (int i = 0; i < 3; i++) begin
            bus.move_valid = 1'b1;
            bus.move_dir   = 2'($urandom);
            @(negedge clk);
            check("over_hold_busy", 32'(bus.busy), 32'(0));
            check("over_hold_clear", 32'(bus.grid_clear), 32'(0));
            check("over_hold_flag", 32'(bus.game_over), 32'(1));
            check("over_hold_count", 32'(bus.move_count), 32'(model_count));
        end
        bus.move_valid = 1'b0;
        do_start(1'b1, 7);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] d    = 2'($urandom);
            logic [3:0] mask = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom);
            bit         ns   = ($urandom % 4 == 0);
            int         hit  = ($urandom % 10 == 0) ? 16 : int'($urandom % 16);
            if ($urandom % 15 == 0) do_start(1'b1, int'($urandom % 16));
            do_move(d, mask, ns, hit);
            if (model_over) do_start(1'b1, int'($urandom % 16));
        end

        // Counter saturation from a preloaded near-max value.
        force dut.move_count_q = 16'hFFFE;
        #1;
        release dut.move_count_q;
        model_count = 16'hFFFE;
        do_move(DIR_LEFT, 4'b0001, 1'b1, 0);
        do_move(DIR_DOWN, 4'b1000, 1'b1, 3);
        check("sat_count", 32'(bus.move_count), 32'hFFFF);

        // Asynchronous reset during MOVE row 1.
        bus.move_valid = 1'b1;
        bus.move_dir   = DIR_UP;
        @(negedge clk);
        bus.move_valid  = 1'b0;
        bus.row_changed = 1'b1;
        @(negedge clk);
        check("arst_pre_row", 32'(bus.row_idx), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        model_count = 16'd0;
        check("arst_ready", 32'(bus.move_ready), 32'(1));
        check("arst_busy", 32'(bus.busy), 32'(0));
        check("arst_outs", 32'({bus.spawn_valid, bus.row_write_en, bus.grid_clear, bus.game_over,
                                bus.use_transposed, bus.push_right, bus.row_idx}), 32'(0));
        check("arst_count", 32'(bus.move_count), 32'(model_count));
        check("arst_state", 32'(dut.state_q), 32'(ST_WAIT_START));
        bus.row_changed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(1'b0, 0);
        do_move(DIR_RIGHT, 4'b1111, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
